// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-queue entry type.
package rv32i_pkg;

    localparam int          XLEN       = 32;
    localparam int          INSN_BYTES = 4;
    localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request issue, filled by responses
// in request order and popped from the head; flush drops every entry at once.
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc,
    input  logic [XLEN-1:0]        alloc_pc,
    input  logic                   fill,
    input  logic [XLEN-1:0]        fill_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] unfilled,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] fill_ptr;

    assign head = entries[head_ptr];

    // Alloc, fill and pop never hit the same slot: tail, oldest-unfilled and a filled
    // head are distinct whenever their enables can be high together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the entry array is reset so the head shows RESET_PC and a zero word out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '{pc: RESET_PC, data: '0, filled: 1'b0};
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            unfilled <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            unfilled <= '0;
        end else begin
            if (alloc) begin
                entries[tail_ptr].pc     <= alloc_pc;
                entries[tail_ptr].filled <= 1'b0;
                tail_ptr                 <= tail_ptr + 1'b1;
            end
            if (fill) begin
                entries[fill_ptr].data   <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + 1'b1;
            end
            if (pop) begin
                entries[head_ptr].filled <= 1'b0;
                head_ptr                 <= head_ptr + 1'b1;
            end
            count    <= count + CNT_W'(alloc) - CNT_W'(pop);
            unfilled <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, imem request/response handshake, redirect flush.
// Optional FETCH_MISALIGN_EN adds fetch_misaligned and halts fetch after a misaligned redirect.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int               CNT_W  = $clog2(DEPTH) + 1;
    localparam int               DROP_W = 8;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   redirect_target;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  unfilled;
    fetch_entry_t      head;
    logic              issue;
    logic              rsp_fill;
    logic              pop;
    logic              halted;

`ifdef FETCH_MISALIGN_EN
    logic misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned <= 1'b0;
        end else if (redirect_valid) begin
            misaligned <= |redirect_pc[1:0];
        end
    end

    assign fetch_misaligned = misaligned;
    assign halted           = misaligned;
    assign redirect_target  = redirect_pc;
`else
    assign halted           = 1'b0;
    assign redirect_target  = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    // Registered count only: a pop of a full queue opens a slot one cycle later.
    assign imem_req_valid = !rst && !redirect_valid && !halted && (count < FULL);
    assign imem_addr      = {pc[XLEN-1:2], 2'b00};
    assign issue          = imem_req_valid && imem_req_ready;
    assign rsp_fill       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid && (unfilled != '0);
    assign pop            = if_valid && if_ready && !redirect_valid;

    always_comb begin
        // NOTE: default first so every path assigns drop_next and no latch is inferred.
        drop_next = drop_cnt;
        if (redirect_valid) begin
            drop_next = drop_cnt + DROP_W'(unfilled);
        end
        if (imem_rsp_valid && ((drop_cnt != '0) || (redirect_valid && (unfilled != '0)))) begin
            drop_next = drop_next - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (issue) begin
                pc <= pc + XLEN'(INSN_BYTES);
            end
        end
    end

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .alloc     (issue),
        .alloc_pc  (imem_addr),
        .fill      (rsp_fill),
        .fill_data (imem_rsp_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .unfilled  (unfilled),
        .head      (head)
    );

    assign if_valid       = head.filled;
    assign if_instruction = head.data;
    assign if_pc          = head.pc;

    // A response with nothing to fill and nothing to drop means the memory broke ordering.
    assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> ((drop_cnt != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model with variable latency, directed
// scenarios (latency, stall, redirects, wrap, misaligned target) and a randomised soak.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misaligned;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc)
`ifdef FETCH_MISALIGN_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;

    mem_req_t    mq[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    logic [31:0] exp_pc = RESET_PC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic check_pop(input string name, input int idx, input logic [31:0] req);
        check(name, (idx < pop_log.size()) ? pop_log[idx] : 32'hDEAD_BEEF, req);
    endtask

    // One clock cycle: drive inputs at the falling edge, record accepts, wait for the next falling edge.
    task automatic tick(input logic redir, input logic [31:0] rpc, input logic ifr);
        int lat;
        int due;
        cyc++;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = ifr;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ XOR_KEY;
            void'(mq.pop_front());
        end
        #1;
        if (redir) begin
            check("no_issue_on_redirect", 32'(imem_req_valid), 32'd0);
            exp_q.delete();
`ifdef FETCH_MISALIGN_EN
            exp_pc = rpc;
`else
            exp_pc = rpc & 32'hFFFF_FFFC;
`endif
        end else if (imem_req_valid && imem_req_ready) begin
            check("issue_addr", imem_addr, exp_pc);
            n_acc++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_addr, due: due});
            exp_q.push_back('{pc: imem_addr, insn: imem_addr ^ XOR_KEY});
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq.delete();
        exp_q.delete();
        exp_pc   = RESET_PC;
        last_due = cyc;
        n_acc    = 0;
        n_pop    = 0;
        #1;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_pc", if_pc, RESET_PC);
        check("rst_if_insn", if_instruction, 32'd0);
`ifdef FETCH_MISALIGN_EN
        check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every IF/ID handshake is compared against the oldest expected instruction.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && if_valid && if_ready && !redirect_valid) begin
            n_pop++;
            pop_log.push_back(if_pc);
            check("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", if_pc, e.pc);
                check("sb_insn", if_instruction, e.insn);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
        $fatal(1);
    end

    initial begin
        int first_acc;
        int first_valid;
        int mark;
        int p0;

        // Latency and steady-state throughput with a 1-cycle memory.
        @(negedge clk);
        do_reset();
        first_acc   = -1;
        first_valid = -1;
        for (int i = 0; i < 20 && first_valid < 0; i++) begin
            if (if_valid) first_valid = cyc + 1;
            else begin
                tick(1'b0, '0, 1'b1);
                if (first_acc < 0 && n_acc > 0) first_acc = cyc;
            end
        end
        check("first_valid_latency", 32'(first_valid - first_acc), 32'd2);
        check("first_pc", if_pc, RESET_PC);
        p0 = n_pop;
        for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1);
        check("steady_throughput", 32'(n_pop - p0), 32'd10);

        // Stall at pc 8 for 5 cycles.
        do_reset();
        for (int i = 0; i < 30 && !(if_valid && if_pc == 32'h8); i++) tick(1'b0, '0, 1'b1);
        check("reach_pc8", 32'(if_valid && if_pc == 32'h8), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc", if_pc, 32'h8);
            check("stall_insn", if_instruction, 32'h8 ^ XOR_KEY);
            tick(1'b0, '0, 1'b0);
        end
        check("stall_inflight", 32'(n_acc - n_pop), 32'(DEPTH));
        check("stall_req_blocked", 32'(imem_req_valid), 32'd0);
        mark = pop_log.size();
        for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);
        check_pop("resume_0", mark, 32'h8);
        check_pop("resume_1", mark + 1, 32'hC);
        check_pop("resume_2", mark + 2, 32'h10);

        // Redirect with two requests outstanding on a 3-cycle memory.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 10 && n_acc < 2; i++) tick(1'b0, '0, 1'b1);
        check("two_outstanding", 32'(n_acc), 32'd2);
        mark = pop_log.size();
        tick(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 15; i++) tick(1'b0, '0, 1'b1);
        check_pop("redir_first", mark, 32'h100);
        check_pop("redir_second", mark + 1, 32'h104);

        // Redirect colliding with a response and a pop, then a second redirect.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1);
        check("pop_at_redirect", 32'(if_valid), 32'd1);
        mark = pop_log.size();
        tick(1'b1, 32'h180, 1'b1);
        tick(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 12; i++) tick(1'b0, '0, 1'b1);
        check_pop("b2b_first", mark, 32'h200);
        check_pop("b2b_second", mark + 1, 32'h204);

        // PC wrap-around.
        do_reset();
        tick(1'b1, 32'hFFFF_FFF8, 1'b1);
        mark = pop_log.size();
        for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1);
        check_pop("wrap_0", mark, 32'hFFFF_FFF8);
        check_pop("wrap_1", mark + 1, 32'hFFFF_FFFC);
        check_pop("wrap_2", mark + 2, 32'h0);
        check_pop("wrap_3", mark + 3, 32'h4);

        // Misaligned redirect target.
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);
        mark = pop_log.size();
        tick(1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_EN
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b1);
            check("misaligned_flag", 32'(fetch_misaligned), 32'd1);
            check("misaligned_no_req", 32'(imem_req_valid), 32'd0);
        end
        check("misaligned_no_pop", 32'(pop_log.size() - mark), 32'd0);
        tick(1'b1, 32'h300, 1'b1);
        tick(1'b0, '0, 1'b1);
        check("misaligned_cleared", 32'(fetch_misaligned), 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1);
        check_pop("aligned_resume", mark, 32'h300);
`else
        for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1);
        check_pop("low_bits_ignored", mark, 32'h100);
`endif

        // Randomised soak: random ready, 1-3 cycle latency, random stalls and redirects.
        do_reset();
        lat_min   = 1;
        lat_max   = 3;
        ready_pct = 60;
        p0 = n_pop;
        for (int i = 0; i < 1000; i++) begin
            tick(($urandom_range(99) < 3), $urandom & 32'hFFFF_FFFC, ($urandom_range(99) < 75));
        end
        check("soak_progress", 32'(n_pop - p0 > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
